// File: rtl/milestone_sequencer_pkg.sv
// Shared types and constants for the image decompressor: SRAM geometry, the SRAM memory map,
// milestone identifiers and the top-level sequencer state type.
package milestone_sequencer_pkg;

    localparam int unsigned SRAM_ADDR_W             = 18;
    localparam int unsigned SRAM_DATA_W             = 16;
    localparam int unsigned WDOG_W                  = 23;
    localparam int unsigned DEFAULT_NUM_STAGES      = 3;
    localparam int unsigned DEFAULT_WATCHDOG_CYCLES = 4194304;

    // SRAM memory map: YUV source segments, intermediate coefficients, RGB output
    localparam logic [SRAM_ADDR_W-1:0] Y_BASE_ADDR   = 18'd0;
    localparam logic [SRAM_ADDR_W-1:0] U_BASE_ADDR   = 18'd38400;
    localparam logic [SRAM_ADDR_W-1:0] V_BASE_ADDR   = 18'd57600;
    localparam logic [SRAM_ADDR_W-1:0] PRE_IDCT_ADDR = 18'd76800;
    localparam logic [SRAM_ADDR_W-1:0] RGB_BASE_ADDR = 18'd146944;

    typedef enum logic [1:0] {
        MilestoneLossless,
        MilestoneIdct,
        MilestoneColour
    } milestone_e;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StGap,
        StFinish
    } seq_state_e;

endpackage

// File: rtl/milestone_sequencer_if.sv
// Stage-facing and SRAM-facing bus of the sequencer. The master side is the sequencer itself;
// the slave side is the stage bank plus the SRAM.
interface milestone_sequencer_if
    import milestone_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) ();

    logic [NUM_STAGES-1:0]             stage_enable;
    logic [NUM_STAGES-1:0]             stage_done;
    logic [SRAM_ADDR_W*NUM_STAGES-1:0] stage_sram_address;
    logic [SRAM_DATA_W*NUM_STAGES-1:0] stage_sram_write_data;
    logic [NUM_STAGES-1:0]             stage_sram_we_n;
    logic [SRAM_ADDR_W-1:0]            sram_address;
    logic [SRAM_DATA_W-1:0]            sram_write_data;
    logic                              sram_we_n;

    modport master (
        output stage_enable,
        output sram_address,
        output sram_write_data,
        output sram_we_n,
        input  stage_done,
        input  stage_sram_address,
        input  stage_sram_write_data,
        input  stage_sram_we_n
    );

    modport slave (
        input  stage_enable,
        input  sram_address,
        input  sram_write_data,
        input  sram_we_n,
        output stage_done,
        output stage_sram_address,
        output stage_sram_write_data,
        output stage_sram_we_n
    );

endinterface

// File: rtl/milestone_sequencer_sram_port_mux.sv
// N:1 combinational selector of per-stage SRAM signals; forced idle drives a safe no-write
// pattern (we_n high, address and data zero).
module milestone_sequencer_sram_port_mux
    import milestone_sequencer_pkg::*;
#(
    parameter int unsigned N     = DEFAULT_NUM_STAGES,
    parameter int unsigned SEL_W = 2
) (
    input  logic [SEL_W-1:0]         i_sel,
    input  logic                     i_force_idle,
    input  logic [SRAM_ADDR_W*N-1:0] i_address,
    input  logic [SRAM_DATA_W*N-1:0] i_write_data,
    input  logic [N-1:0]             i_we_n,
    output logic [SRAM_ADDR_W-1:0]   o_address,
    output logic [SRAM_DATA_W-1:0]   o_write_data,
    output logic                     o_we_n
);

    always_comb begin
        o_address    = '0;
        o_write_data = '0;
        o_we_n       = 1'b1;
        if (!i_force_idle) begin
            for (int i = 0; i < int'(N); i++) begin
                if (i_sel == SEL_W'(i)) begin
                    o_address    = i_address[i*SRAM_ADDR_W +: SRAM_ADDR_W];
                    o_write_data = i_write_data[i*SRAM_DATA_W +: SRAM_DATA_W];
                    o_we_n       = i_we_n[i];
                end
            end
        end
    end

endmodule

// File: rtl/milestone_sequencer.sv
// Top-level decode scheduler: runs the stages in index order, owns the single SRAM port,
// inserts an idle bus cycle between stages and guards each stage with a watchdog.
module milestone_sequencer
    import milestone_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = DEFAULT_NUM_STAGES,
    parameter int unsigned WATCHDOG_CYCLES = DEFAULT_WATCHDOG_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    milestone_sequencer_if.master bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [1:0]            o_active_stage
);

    localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_W'(WATCHDOG_CYCLES - 1);
    localparam logic [1:0]        LAST_STAGE = 2'(NUM_STAGES - 1);

    seq_state_e          r_state;
    seq_state_e          w_state_d;
    logic [1:0]          r_active_stage;
    logic [1:0]          w_active_d;
    logic [WDOG_W-1:0]   r_wdog;
    logic [WDOG_W-1:0]   w_wdog_d;
    logic                r_error;
    logic                w_error_d;
    logic [NUM_STAGES-1:0] w_onehot;
    logic                w_done_sel;
    logic                w_bus_idle;

    assign w_onehot   = NUM_STAGES'(1) << r_active_stage;
    // Done bits from any stage other than the bus owner are dropped here
    assign w_done_sel = |(bus.stage_done & w_onehot);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= StIdle;
            r_active_stage <= '0;
            r_wdog         <= '0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_active_stage <= w_active_d;
            r_wdog         <= w_wdog_d;
            r_error        <= w_error_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_active_d = r_active_stage;
        w_wdog_d   = r_wdog;
        w_error_d  = r_error;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d  = StLaunch;
                    w_active_d = '0;
                    w_error_d  = 1'b0;
                end
            end
            StLaunch: begin
                w_wdog_d  = '0;
                w_state_d = StWait;
            end
            StWait: begin
                w_wdog_d = r_wdog + 1'b1;
                // A done arriving on the last permitted cycle beats the timeout
                if (w_done_sel) begin
                    w_state_d = StGap;
                end else if (r_wdog == WDOG_LAST) begin
                    w_error_d = 1'b1;
                    w_state_d = StIdle;
                end
            end
            StGap: begin
                if (r_active_stage == LAST_STAGE) begin
                    w_state_d = StFinish;
                end else begin
                    w_active_d = r_active_stage + 2'd1;
                    w_state_d  = StLaunch;
                end
            end
            StFinish: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign bus.stage_enable = (r_state == StLaunch) ? w_onehot : '0;
    assign w_bus_idle       = !((r_state == StLaunch) || (r_state == StWait));
    assign o_busy           = (r_state == StLaunch) || (r_state == StWait) || (r_state == StGap);
    assign o_done           = (r_state == StFinish);
    assign o_error          = r_error;
    assign o_active_stage   = r_active_stage;

    milestone_sequencer_sram_port_mux #(
        .N     (NUM_STAGES),
        .SEL_W (2)
    ) u_sram_mux (
        .i_sel        (r_active_stage),
        .i_force_idle (w_bus_idle),
        .i_address    (bus.stage_sram_address),
        .i_write_data (bus.stage_sram_write_data),
        .i_we_n       (bus.stage_sram_we_n),
        .o_address    (bus.sram_address),
        .o_write_data (bus.sram_write_data),
        .o_we_n       (bus.sram_we_n)
    );

endmodule

// File: tb/tb_milestone_sequencer.sv
// Self-checking bench: a cycle-level timeline model predicts enables, Busy/Done/Error and SRAM
// ownership from the stage done delays; instance B uses a 16-cycle watchdog.
module tb_milestone_sequencer;
    import milestone_sequencer_pkg::*;

    localparam int NS   = 3;
    localparam int MAXC = 200;
    localparam int WD_A = DEFAULT_WATCHDOG_CYCLES;
    localparam int WD_B = 16;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    logic [NS-1:0]    drv_done;
    logic [18*NS-1:0] drv_addr;
    logic [16*NS-1:0] drv_data;
    logic [NS-1:0]    drv_we_n;
    logic             use_b;
    logic             pin0;

    logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [1:0] act_a, act_b;

    milestone_sequencer_if #(.NUM_STAGES(NS)) bus_a ();
    milestone_sequencer_if #(.NUM_STAGES(NS)) bus_b ();

    assign bus_a.stage_done            = use_b ? '0 : drv_done;
    assign bus_b.stage_done            = use_b ? drv_done : '0;
    assign bus_a.stage_sram_address    = drv_addr;
    assign bus_b.stage_sram_address    = drv_addr;
    assign bus_a.stage_sram_write_data = drv_data;
    assign bus_b.stage_sram_write_data = drv_data;
    assign bus_a.stage_sram_we_n       = drv_we_n;
    assign bus_b.stage_sram_we_n       = drv_we_n;

    milestone_sequencer #(.NUM_STAGES(NS), .WATCHDOG_CYCLES(WD_A)) dut (
        .clk(clk), .rst(rst), .i_start(start), .bus(bus_a.master),
        .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .o_active_stage(act_a)
    );

    milestone_sequencer #(.NUM_STAGES(NS), .WATCHDOG_CYCLES(WD_B)) dut_wd (
        .clk(clk), .rst(rst), .i_start(start), .bus(bus_b.master),
        .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .o_active_stage(act_b)
    );

    logic [40:0] vec_a, vec_b;
    assign vec_a = {bus_a.stage_enable, busy_a, done_a, err_a, bus_a.sram_we_n,
                    bus_a.sram_address, bus_a.sram_write_data};
    assign vec_b = {bus_b.stage_enable, busy_b, done_b, err_b, bus_b.sram_we_n,
                    bus_b.sram_address, bus_b.sram_write_data};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int delay [NS];
    int rem   [NS];

    logic [40:0]      obs_vec  [MAXC];
    logic [1:0]       obs_act  [MAXC];
    logic [18*NS-1:0] rec_addr [MAXC];
    logic [16*NS-1:0] rec_data [MAXC];
    logic [NS-1:0]    rec_we   [MAXC];
    logic [NS-1:0]    inj      [MAXC];

    logic [NS-1:0] exp_en    [MAXC];
    bit            exp_busy  [MAXC];
    bit            exp_done  [MAXC];
    bit            exp_err   [MAXC];
    int            exp_owner [MAXC];
    int            exp_act   [MAXC];

    // One clock; stage responders pulse done in the delay-th WAIT cycle after their enable
    task automatic tick();
        logic [NS-1:0] en;
        @(posedge clk);
        #1;
        cyc++;
        en = use_b ? bus_b.stage_enable : bus_a.stage_enable;
        for (int i = 0; i < NS; i++) begin
            drv_done[i] = 1'b0;
            if (en[i]) begin
                rem[i] = delay[i];
            end else if (rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) drv_done[i] = 1'b1;
            end
        end
        drv_addr = 54'({$urandom(), $urandom()});
        drv_data = 48'({$urandom(), $urandom()});
        drv_we_n = 3'($urandom());
        if (pin0) begin
            drv_we_n[0]    = 1'b0;
            drv_addr[17:0] = 18'h00100;
        end
        if (cyc >= 0 && cyc < MAXC) begin
            drv_done      = drv_done | inj[cyc];
            rec_addr[cyc] = drv_addr;
            rec_data[cyc] = drv_data;
            rec_we[cyc]   = drv_we_n;
        end
        #1;
        if (cyc >= 0 && cyc < MAXC) begin
            obs_vec[cyc] = use_b ? vec_b : vec_a;
            obs_act[cyc] = use_b ? act_b : act_a;
        end
    endtask

    task automatic clear_model();
        for (int n = 0; n < MAXC; n++) begin
            exp_en[n]    = '0;
            exp_busy[n]  = 1'b0;
            exp_done[n]  = 1'b0;
            exp_err[n]   = 1'b0;
            exp_owner[n] = -1;
            exp_act[n]   = -1;
            inj[n]       = '0;
        end
        exp_act[0] = 0;
    endtask

    // Reset is held over one edge; the cycle after it is cycle 0
    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NS; i++) rem[i] = 0;
        clear_model();
        cyc = -1;
        tick();
        rst = 1'b0;
    endtask

    // Timeline of one run whose Start is sampled in cycle s; returns the IDLE cycle after it
    task automatic model_run(input int s, input int wd, output int end_c);
        int  t;
        int  last;
        bit  timed;
        bit  stop;
        stop  = 1'b0;
        end_c = MAXC;
        for (int n = s + 1; n < MAXC; n++) exp_err[n] = 1'b0;
        t = s + 1;
        for (int i = 0; i < NS; i++) begin
            if (!stop) begin
                if (t < MAXC) exp_en[t][i] = 1'b1;
                timed = (delay[i] == 0) || (delay[i] > wd);
                last  = timed ? t + wd : t + delay[i];
                for (int n = t; n <= last && n < MAXC; n++) begin
                    exp_owner[n] = i;
                    exp_busy[n]  = 1'b1;
                    exp_act[n]   = i;
                end
                if (timed) begin
                    for (int n = last + 1; n < MAXC; n++) exp_err[n] = 1'b1;
                    end_c = last + 1;
                    stop  = 1'b1;
                end else begin
                    if (last + 1 < MAXC) begin
                        exp_busy[last + 1] = 1'b1;
                        exp_act[last + 1]  = i;
                    end
                    t = last + 2;
                end
            end
        end
        if (!stop) begin
            if (t < MAXC) exp_done[t] = 1'b1;
            end_c = t + 1;
        end
    endtask

    function automatic logic [40:0] exp_vec(input int n);
        int          o;
        logic [17:0] a;
        logic [15:0] d;
        logic        w;
        o = exp_owner[n];
        a = '0;
        d = '0;
        w = 1'b1;
        if (o >= 0) begin
            a = rec_addr[n][o*18 +: 18];
            d = rec_data[n][o*16 +: 16];
            w = rec_we[n][o];
        end
        return {exp_en[n], exp_busy[n], exp_done[n], exp_err[n], w, a, d};
    endfunction

    task automatic run_to(input int upto, input int st_lo, input int st_hi);
        while (cyc < upto) begin
            start = (cyc >= st_lo) && (cyc <= st_hi);
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        use_b = 1'b0;
        do_reset();
        n_checks += 8;
        if (obs_vec[0][40:38] !== 3'b000) begin
            n_fail++; $display("FAIL reset_enable: got %b, expected 000", obs_vec[0][40:38]);
        end
        if (obs_vec[0][37] !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, expected 0", obs_vec[0][37]);
        end
        if (obs_vec[0][36] !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b, expected 0", obs_vec[0][36]);
        end
        if (obs_vec[0][35] !== 1'b0) begin
            n_fail++; $display("FAIL reset_error: got %b, expected 0", obs_vec[0][35]);
        end
        if (obs_vec[0][34] !== 1'b1) begin
            n_fail++; $display("FAIL reset_we_n: got %b, expected 1", obs_vec[0][34]);
        end
        if (obs_vec[0][33:16] !== 18'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h, expected 0", obs_vec[0][33:16]);
        end
        if (obs_vec[0][15:0] !== 16'h0) begin
            n_fail++; $display("FAIL reset_data: got %h, expected 0", obs_vec[0][15:0]);
        end
        if (obs_act[0] !== 2'd0) begin
            n_fail++; $display("FAIL reset_active: got %0d, expected 0", obs_act[0]);
        end
    endtask

    task automatic test_nominal();
        int e;
        use_b = 1'b0;
        do_reset();
        delay = '{10, 20, 5};
        pin0  = 1'b1;
        model_run(0, WD_A, e);
        run_to(e + 2, 0, 0);
        pin0 = 1'b0;
        for (int n = 0; n <= e + 1; n++) begin
            n_checks++;
            if (obs_vec[n] !== exp_vec(n)) begin
                n_fail++;
                $display("FAIL nominal_trace cyc %0d: got %h, expected %h", n, obs_vec[n], exp_vec(n));
            end
            if (exp_act[n] >= 0) begin
                n_checks++;
                if (obs_act[n] !== 2'(exp_act[n])) begin
                    n_fail++;
                    $display("FAIL nominal_active cyc %0d: got %0d, expected %0d", n, obs_act[n], exp_act[n]);
                end
            end
        end
        // Hand-over cycles at 12 and 34 must not leak stage 0's pinned write
        n_checks += 2;
        if (obs_vec[12][34:16] !== {1'b1, 18'h0}) begin
            n_fail++; $display("FAIL nominal_gap0: got %h, expected %h", obs_vec[12][34:16], {1'b1, 18'h0});
        end
        if (obs_vec[34][34:16] !== {1'b1, 18'h0}) begin
            n_fail++; $display("FAIL nominal_gap1: got %h, expected %h", obs_vec[34][34:16], {1'b1, 18'h0});
        end
    endtask

    task automatic test_spurious_done();
        int e;
        use_b = 1'b0;
        do_reset();
        delay  = '{4, 3, 2};
        inj[1] = 3'b001;
        inj[3] = 3'b100;
        model_run(0, WD_A, e);
        run_to(e + 2, 0, 0);
        for (int n = 0; n <= e + 1; n++) begin
            n_checks++;
            if (obs_vec[n] !== exp_vec(n)) begin
                n_fail++;
                $display("FAIL spurious_trace cyc %0d: got %h, expected %h", n, obs_vec[n], exp_vec(n));
            end
        end
    endtask

    task automatic test_random();
        int e;
        int s;
        use_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < NS; i++) delay[i] = int'($urandom_range(1, 12));
            s = int'($urandom_range(0, 3));
            model_run(s, WD_A, e);
            run_to(e + 2, s, s);
            for (int n = 0; n <= e + 1; n++) begin
                n_checks++;
                if (obs_vec[n] !== exp_vec(n)) begin
                    n_fail++;
                    $display("FAIL random_trace run %0d cyc %0d: got %h, expected %h", k, n, obs_vec[n], exp_vec(n));
                end
                if (exp_act[n] >= 0) begin
                    n_checks++;
                    if (obs_act[n] !== 2'(exp_act[n])) begin
                        n_fail++;
                        $display("FAIL random_active run %0d cyc %0d: got %0d, expected %0d", k, n, obs_act[n], exp_act[n]);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int e;
        use_b = 1'b0;
        do_reset();
        delay = '{5, 30, 5};
        model_run(0, WD_A, e);
        run_to(15, 0, 0);
        for (int n = 0; n <= 15; n++) begin
            n_checks++;
            if (obs_vec[n] !== exp_vec(n)) begin
                n_fail++;
                $display("FAIL midreset_pre cyc %0d: got %h, expected %h", n, obs_vec[n], exp_vec(n));
            end
        end
        do_reset();
        n_checks += 3;
        if (obs_vec[0][34] !== 1'b1) begin
            n_fail++; $display("FAIL midreset_we_n: got %b, expected 1", obs_vec[0][34]);
        end
        if (obs_vec[0][37] !== 1'b0) begin
            n_fail++; $display("FAIL midreset_busy: got %b, expected 0", obs_vec[0][37]);
        end
        if (obs_act[0] !== 2'd0) begin
            n_fail++; $display("FAIL midreset_active: got %0d, expected 0", obs_act[0]);
        end
        delay = '{2, 2, 2};
        model_run(0, WD_A, e);
        run_to(e + 2, 0, 0);
        for (int n = 0; n <= e + 1; n++) begin
            n_checks++;
            if (obs_vec[n] !== exp_vec(n)) begin
                n_fail++;
                $display("FAIL midreset_rerun cyc %0d: got %h, expected %h", n, obs_vec[n], exp_vec(n));
            end
        end
    endtask

    task automatic test_watchdog();
        int e1, e2, e3, s3;
        use_b = 1'b1;
        do_reset();
        delay = '{3, 0, 4};
        model_run(0, WD_B, e1);
        run_to(26, 0, 0);
        delay = '{3, 3, 3};
        model_run(26, WD_B, e2);
        run_to(e2 + 2, 26, 26);
        // Done on the very last permitted WAIT cycle must still be accepted
        delay = '{1, 16, 1};
        s3    = e2 + 2;
        model_run(s3, WD_B, e3);
        run_to(e3 + 2, s3, s3);
        for (int n = 0; n <= e3 + 1; n++) begin
            n_checks++;
            if (obs_vec[n] !== exp_vec(n)) begin
                n_fail++;
                $display("FAIL watchdog_trace cyc %0d: got %h, expected %h", n, obs_vec[n], exp_vec(n));
            end
        end
        n_checks += 3;
        if (obs_vec[22][35] !== 1'b0) begin
            n_fail++; $display("FAIL watchdog_early: got %b, expected 0", obs_vec[22][35]);
        end
        if (obs_vec[e1][35] !== 1'b1) begin
            n_fail++; $display("FAIL watchdog_error: got %b, expected 1", obs_vec[e1][35]);
        end
        if (obs_vec[27][35] !== 1'b0) begin
            n_fail++; $display("FAIL watchdog_clear: got %b, expected 0", obs_vec[27][35]);
        end
        use_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        int s, e, exp_cnt, got_cnt;
        use_b = 1'b0;
        do_reset();
        delay   = '{2, 2, 2};
        s       = 0;
        exp_cnt = 0;
        while (s <= 19) begin
            model_run(s, WD_A, e);
            exp_cnt++;
            s = e;
        end
        run_to(32, 0, 19);
        got_cnt = 0;
        for (int n = 0; n <= 31; n++) begin
            got_cnt += int'(obs_vec[n][36]);
            n_checks++;
            if (obs_vec[n] !== exp_vec(n)) begin
                n_fail++;
                $display("FAIL b2b_trace cyc %0d: got %h, expected %h", n, obs_vec[n], exp_vec(n));
            end
            n_checks++;
            if (!$onehot0(obs_vec[n][40:38])) begin
                n_fail++;
                $display("FAIL b2b_overlap cyc %0d: got %b, expected at most one bit", n, obs_vec[n][40:38]);
            end
        end
        n_checks++;
        if (got_cnt != exp_cnt) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d, expected %0d", got_cnt, exp_cnt);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        use_b    = 1'b0;
        pin0     = 1'b0;
        drv_done = '0;
        drv_addr = '0;
        drv_data = '0;
        drv_we_n = '1;
        delay    = '{1, 1, 1};
        cyc      = -1;
        test_reset();
        test_nominal();
        test_spurious_done();
        test_random();
        test_mid_reset();
        test_watchdog();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
